// File: rtl/spmp_csr_bank.sv
// ============================================================================
// spmp_csr_bank
// ----------------------------------------------------------------------------
// CSR-side register bank for the supervisor PMP (SPMP). It holds the
// spmpcfg bytes and spmpaddr registers, serves CSR read/write requests
// from the CSR file, enforces lock semantics and drives the packed
// configuration to the SPMP checkers.
//
// Ports:
//   clk_i        clock
//   rst_i        asynchronous active-high reset
//   req_valid_i  request valid
//   req_ready_o  request ready (= !rsp_valid_o | rsp_ready_i)
//   req_we_i     1 = write, 0 = read
//   req_addr_i   12-bit CSR address
//   req_wdata_i  write data (XLEN)
//   rsp_valid_o  response valid, registered, one cycle after acceptance
//   rsp_ready_i  response ready
//   rsp_rdata_o  read data; 0 on writes and on errors
//   rsp_err_o    illegal CSR access
//   spmp_cfg_o   packed cfg bytes, entry i at [8i+7:8i]
//   spmp_addr_o  packed spmpaddr registers, entry i at [(PLEN-2)*i +: PLEN-2]
// ============================================================================
module spmp_csr_bank #(
    parameter int unsigned                      NR_ENTRIES   = 64,
    parameter int unsigned                      XLEN         = 64,
    parameter int unsigned                      PLEN         = 56,
    parameter logic [NR_ENTRIES*8-1:0]          CFG_RST_VAL  = '0,
    parameter logic [NR_ENTRIES*(PLEN-2)-1:0]   ADDR_RST_VAL = '0
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            req_valid_i,
    output logic                            req_ready_o,
    input  logic                            req_we_i,
    input  logic [11:0]                     req_addr_i,
    input  logic [XLEN-1:0]                 req_wdata_i,
    output logic                            rsp_valid_o,
    input  logic                            rsp_ready_i,
    output logic [XLEN-1:0]                 rsp_rdata_o,
    output logic                            rsp_err_o,
    output logic [NR_ENTRIES*8-1:0]         spmp_cfg_o,
    output logic [NR_ENTRIES*(PLEN-2)-1:0]  spmp_addr_o
);

    localparam int unsigned AW     = PLEN - 2;
    localparam int unsigned NB     = XLEN / 8;      // cfg bytes per CSR
    localparam int unsigned NB_LOG = $clog2(NB);

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic            rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0] rsp_rdata_q, rsp_rdata_d;
    logic            rsp_err_q,   rsp_err_d;
    logic            accept;

    assign req_ready_o = !rsp_valid_q || rsp_ready_i;
    assign accept      = req_valid_i && req_ready_o;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [3:0]  cfg_n;
    logic [5:0]  cfg_base;      // first entry covered by the cfg CSR
    logic [5:0]  cfg_grp;       // CSR group index (entries / NB)
    logic        is_cfg;
    logic        cfg_legal;
    logic [11:0] addr_off;
    logic [5:0]  addr_idx;
    logic        addr_legal;
    logic        req_err;
    logic        wr_cfg;
    logic        wr_addr;

    assign cfg_n    = req_addr_i[3:0];
    // Both at XLEN=32 (N*4 entries) and XLEN=64 (even N, N/2*8 entries)
    // the first entry of spmpcfgN is N*4.
    assign cfg_base = {cfg_n, 2'b00};
    assign cfg_grp  = cfg_base >> NB_LOG;
    assign is_cfg   = (req_addr_i[11:4] == 8'h1A);
    assign cfg_legal = is_cfg
                     && !((XLEN == 64) && cfg_n[0])
                     && (32'(cfg_base) < NR_ENTRIES);

    assign addr_off   = req_addr_i - 12'h1B0;
    assign addr_idx   = addr_off[5:0];
    assign addr_legal = (req_addr_i >= 12'h1B0) && (32'(addr_off) < NR_ENTRIES);

    assign req_err = !(cfg_legal || addr_legal);
    assign wr_cfg  = accept && req_we_i && cfg_legal;
    assign wr_addr = accept && req_we_i && addr_legal;

    // Write data resized to the spmpaddr width
    logic [AW-1:0] wdata_addr;
    generate
        if (AW <= XLEN) begin : g_wd_trunc
            assign wdata_addr = req_wdata_i[AW-1:0];
        end else begin : g_wd_ext
            assign wdata_addr = {{(AW-XLEN){1'b0}}, req_wdata_i};
        end
    endgenerate

    // ------------------------------------------------------------------
    // Per-entry cfg / addr registers
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NR_ENTRIES; gi++) begin : g_entry
            localparam int unsigned K   = gi % NB;
            localparam logic [5:0]  GRP = 6'(gi / NB);

            logic [7:0]    cfg_q, cfg_d;
            logic [AW-1:0] addr_q, addr_d;
            logic [7:0]    wbyte;
            logic          next_tor_lock;

            assign wbyte = req_wdata_i[8*K +: 8];

            // A locked TOR entry above also protects this entry's address,
            // since it is the lower bound of that TOR region.
            if (gi + 1 < NR_ENTRIES) begin : g_next
                assign next_tor_lock = spmp_cfg_o[8*(gi+1)+7]
                                    && (spmp_cfg_o[8*(gi+1)+3 +: 2] == 2'b01);
            end else begin : g_last
                assign next_tor_lock = 1'b0;
            end

            always_comb begin
                cfg_d = cfg_q;
                // W=1,R=0 is reserved: such a byte leaves the entry untouched.
                if (wr_cfg && (cfg_grp == GRP) && !cfg_q[7]
                    && !(wbyte[1] && !wbyte[0])) begin
                    cfg_d = wbyte & 8'h9F;
                end
            end

            always_comb begin
                addr_d = addr_q;
                if (wr_addr && (addr_idx == 6'(gi)) && !cfg_q[7] && !next_tor_lock) begin
                    addr_d = wdata_addr;
                end
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    cfg_q  <= CFG_RST_VAL[8*gi +: 8] & 8'h9F;
                    addr_q <= ADDR_RST_VAL[AW*gi +: AW];
                end else begin
                    cfg_q  <= cfg_d;
                    addr_q <= addr_d;
                end
            end

            assign spmp_cfg_o[8*gi +: 8]    = cfg_q;
            assign spmp_addr_o[AW*gi +: AW] = addr_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read path
    // ------------------------------------------------------------------
    // cfg bytes padded with zeros so a CSR that straddles NR_ENTRIES reads
    // 0 for the missing entries and the slice never leaves the vector.
    logic [128*8-1:0] cfg_pad;
    logic [XLEN-1:0]  rd_cfg;
    logic [AW-1:0]    rd_addr_raw;
    logic [XLEN-1:0]  rd_addr;

    always_comb begin
        cfg_pad = '0;
        cfg_pad[NR_ENTRIES*8-1:0] = spmp_cfg_o;
    end

    assign rd_cfg = cfg_pad[{cfg_base, 3'b000} +: XLEN];

    always_comb begin
        rd_addr_raw = '0;
        for (int i = 0; i < NR_ENTRIES; i++) begin
            if (addr_idx == 6'(i)) begin
                rd_addr_raw = spmp_addr_o[AW*i +: AW];
            end
        end
    end

    generate
        if (AW < XLEN) begin : g_rd_ext
            assign rd_addr = {{(XLEN-AW){1'b0}}, rd_addr_raw};
        end else begin : g_rd_trunc
            assign rd_addr = rd_addr_raw[XLEN-1:0];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Response register
    // ------------------------------------------------------------------
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = req_err;
            if (req_we_i || req_err) begin
                rsp_rdata_d = '0;
            end else if (cfg_legal) begin
                rsp_rdata_d = rd_cfg;
            end else begin
                rsp_rdata_d = rd_addr;
            end
        end else if (rsp_ready_i) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_spmp_csr_bank.sv
// Directed testbench for spmp_csr_bank (NR_ENTRIES=64, XLEN=64, PLEN=56).
module tb_spmp_csr_bank;

    localparam int NR = 64;
    localparam int XL = 64;
    localparam int PL = 56;
    localparam int AW = PL - 2;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              req_valid_i;
    logic              req_ready_o;
    logic              req_we_i;
    logic [11:0]       req_addr_i;
    logic [XL-1:0]     req_wdata_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [XL-1:0]     rsp_rdata_o;
    logic              rsp_err_o;
    logic [NR*8-1:0]   spmp_cfg_o;
    logic [NR*AW-1:0]  spmp_addr_o;

    spmp_csr_bank #(
        .NR_ENTRIES (NR),
        .XLEN       (XL),
        .PLEN       (PL)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_we_i    (req_we_i),
        .req_addr_i  (req_addr_i),
        .req_wdata_i (req_wdata_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .spmp_cfg_o  (spmp_cfg_o),
        .spmp_addr_o (spmp_addr_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%016h want 0x%016h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%016h", tag, obs);
        end
    endtask

    function automatic logic [63:0] addr_of(input int i);
        return 64'(spmp_addr_o[AW*i +: AW]);
    endfunction

    // Called at a negedge: presents one request, returns at the next negedge
    // with the response sampled (the response retires at the following edge).
    task automatic xact(input logic we, input logic [11:0] a, input logic [63:0] d,
                        output logic [63:0] rd, output logic er, output logic vld);
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_addr_i  = a;
        req_wdata_i = d;
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        rd  = rsp_rdata_o;
        er  = rsp_err_o;
        vld = rsp_valid_o;
    endtask

    task automatic do_chk(input string tag, input logic we, input logic [11:0] a,
                          input logic [63:0] d, input logic [63:0] exp_rd, input logic exp_err);
        logic [63:0] rd;
        logic        er;
        logic        vld;
        xact(we, a, d, rd, er, vld);
        check_val({tag, ".vld"}, 64'(vld), 64'd1);
        check_val({tag, ".rd"},  rd, exp_rd);
        check_val({tag, ".err"}, 64'(er), 64'(exp_err));
    endtask

    logic [11:0] b2b_addr [4];
    logic [63:0] b2b_exp  [4];

    initial begin
        rst_i       = 1'b1;
        req_valid_i = 1'b0;
        req_we_i    = 1'b0;
        req_addr_i  = '0;
        req_wdata_i = '0;
        rsp_ready_i = 1'b1;
        repeat (2) @(negedge clk_i);

        // Reset state
        check_val("rst.rsp_valid", 64'(rsp_valid_o), 64'd0);
        check_val("rst.req_ready", 64'(req_ready_o), 64'd1);
        check_val("rst.cfg_any",   64'(|spmp_cfg_o), 64'd0);
        rst_i = 1'b0;
        @(negedge clk_i);

        // Basic reads and the odd cfg CSR
        check_val("idle.rsp_valid", 64'(rsp_valid_o), 64'd0);
        do_chk("rd_1a0", 1'b0, 12'h1A0, 64'h0, 64'h0, 1'b0);
        do_chk("rd_1a1", 1'b0, 12'h1A1, 64'h0, 64'h0, 1'b1);

        // Cfg write with lock on entry 1 (0x8F: L=1, A=TOR, XWR)
        do_chk("wr_cfg0", 1'b1, 12'h1A0, 64'h8F0B, 64'h0, 1'b0);
        check_val("cfg_out_a", 64'(spmp_cfg_o[15:0]), 64'h8F0B);
        do_chk("rd_cfg0", 1'b0, 12'h1A0, 64'h0, 64'h8F0B, 1'b0);
        do_chk("wr_cfg0z", 1'b1, 12'h1A0, 64'h0, 64'h0, 1'b0);
        do_chk("rd_cfg0z", 1'b0, 12'h1A0, 64'h0, 64'h8F00, 1'b0);

        // Address lock: entry 0 under locked TOR entry 1, entry 1 locked
        do_chk("wr_a0", 1'b1, 12'h1B0, 64'h1234, 64'h0, 1'b0);
        do_chk("rd_a0", 1'b0, 12'h1B0, 64'h0, 64'h0, 1'b0);
        do_chk("wr_a1", 1'b1, 12'h1B1, 64'h5678, 64'h0, 1'b0);
        do_chk("rd_a1", 1'b0, 12'h1B1, 64'h0, 64'h0, 1'b0);
        do_chk("wr_a2", 1'b1, 12'h1B2, 64'h9ABC, 64'h0, 1'b0);
        check_val("addr2_out", addr_of(2), 64'h9ABC);
        do_chk("rd_a2", 1'b0, 12'h1B2, 64'h0, 64'h9ABC, 1'b0);

        // Reserved W=1,R=0 and reserved-bit masking
        do_chk("wr_wr0", 1'b1, 12'h1A0, 64'h0002_0000, 64'h0, 1'b0);
        do_chk("rd_wr0", 1'b0, 12'h1A0, 64'h0, 64'h8F00, 1'b0);
        do_chk("wr_msk", 1'b1, 12'h1A0, 64'h7F1F_0000, 64'h0, 1'b0);
        do_chk("rd_msk", 1'b0, 12'h1A0, 64'h0, 64'h1F1F_8F00, 1'b0);

        // Illegal accesses change nothing
        do_chk("wr_1a1", 1'b1, 12'h1A1, 64'hFF, 64'h0, 1'b1);
        check_val("cfg_after_err", spmp_cfg_o[63:0], 64'h1F1F_8F00);
        do_chk("rd_1f0", 1'b0, 12'h1F0, 64'h0, 64'h0, 1'b1);
        do_chk("rd_19f", 1'b0, 12'h19F, 64'h0, 64'h0, 1'b1);

        // Top cfg CSR, entries 56..63; byte 0x0A (W without R) skipped
        do_chk("wr_1ae", 1'b1, 12'h1AE, 64'h0B0A_0908_0703_0501, 64'h0, 1'b0);
        do_chk("rd_1ae", 1'b0, 12'h1AE, 64'h0, 64'h0B00_0908_0703_0501, 1'b0);

        // Stall: response held, pending write not applied
        @(negedge clk_i);
        req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 12'h1A0; req_wdata_i = '0;
        rsp_ready_i = 1'b0;
        @(negedge clk_i);
        req_we_i = 1'b1; req_addr_i = 12'h1B3; req_wdata_i = 64'h55;
        for (int i = 0; i < 3; i++) begin
            check_val("stall.req_ready", 64'(req_ready_o), 64'd0);
            check_val("stall.vld",       64'(rsp_valid_o), 64'd1);
            check_val("stall.rd",        rsp_rdata_o, 64'h1F1F_8F00);
            check_val("stall.addr3",     addr_of(3), 64'h0);
            @(negedge clk_i);
        end
        rsp_ready_i = 1'b1;
        #1;
        check_val("release.req_ready", 64'(req_ready_o), 64'd1);
        @(negedge clk_i);
        check_val("rel_wr.vld",   64'(rsp_valid_o), 64'd1);
        check_val("rel_wr.err",   64'(rsp_err_o), 64'd0);
        check_val("rel_wr.addr3", addr_of(3), 64'h55);

        // Four back-to-back reads, one response per cycle
        b2b_addr[0] = 12'h1B0; b2b_exp[0] = 64'h0;
        b2b_addr[1] = 12'h1A0; b2b_exp[1] = 64'h1F1F_8F00;
        b2b_addr[2] = 12'h1B3; b2b_exp[2] = 64'h55;
        b2b_addr[3] = 12'h1AE; b2b_exp[3] = 64'h0B00_0908_0703_0501;
        req_we_i = 1'b0; req_wdata_i = '0; req_addr_i = b2b_addr[0];
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            check_val("b2b.vld", 64'(rsp_valid_o), 64'd1);
            check_val("b2b.rd",  rsp_rdata_o, b2b_exp[i]);
            if (i < 3) req_addr_i = b2b_addr[i+1];
            else       req_valid_i = 1'b0;
        end
        @(negedge clk_i);

        // Reset with a pending response and locked entries
        req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 12'h1A0;
        rsp_ready_i = 1'b0;
        @(negedge clk_i);
        req_valid_i = 1'b0;
        check_val("prerst.vld", 64'(rsp_valid_o), 64'd1);
        rst_i = 1'b1;
        #1;
        check_val("midrst.vld", 64'(rsp_valid_o), 64'd0);
        check_val("midrst.rd",  rsp_rdata_o, 64'h0);
        check_val("midrst.cfg", 64'(|spmp_cfg_o), 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
        check_val("postrst.req_ready", 64'(req_ready_o), 64'd1);
        do_chk("wr_abc", 1'b1, 12'h1B0, 64'hABC, 64'h0, 1'b0);
        do_chk("rd_abc", 1'b0, 12'h1B0, 64'h0, 64'hABC, 1'b0);
        do_chk("wr_a1r", 1'b1, 12'h1B1, 64'h77, 64'h0, 1'b0);
        do_chk("rd_a1r", 1'b0, 12'h1B1, 64'h0, 64'h77, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
